// File: rtl/instr_mem_responder_if.sv
// CPU <-> memory responder bus: read/write requests and registered read return.
// The CPU drives the master side; the memory responder implements the slave side.
interface instr_mem_responder_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
);
  logic                  read_mem;
  logic                  write_mem;
  logic [ADDR_WIDTH-1:0] mem_radrs;
  logic [ADDR_WIDTH-1:0] mem_wadrs;
  logic [DATA_WIDTH-1:0] result;
  logic [DATA_WIDTH-1:0] instruction_fetch;
  logic                  rdata_valid;
  logic                  ready;
  logic                  addr_err;

  modport master (
    output read_mem, write_mem, mem_radrs, mem_wadrs, result,
    input  instruction_fetch, rdata_valid, ready, addr_err
  );

  modport slave (
    input  read_mem, write_mem, mem_radrs, mem_wadrs, result,
    output instruction_fetch, rdata_valid, ready, addr_err
  );
endinterface

// File: rtl/instr_mem_responder.sv
// Memory-side responder for the CPU fetch/store path: self-clears the storage
// array after reset, then serves 1-cycle-latency reads and write-first writes.
module instr_mem_responder #(
  parameter int                    ADDR_WIDTH = 11,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 2048,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  resetn,
  instr_mem_responder_if.slave  bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);

  typedef enum logic {CLEAR, SERVE} state_t;

  state_t                state_reg;
  logic [IDX_W-1:0]      clear_cnt_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic                  rdata_valid_reg;
  logic                  ready_reg;
  logic                  addr_err_reg;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic                  rd_in_range;
  logic                  wr_in_range;
  logic [IDX_W-1:0]      rd_idx;
  logic [IDX_W-1:0]      wr_idx;
  logic                  wr_hits_rd;

  logic                  ram_we;
  logic [IDX_W-1:0]      ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;

  assign rd_in_range = {1'b0, bus.mem_radrs} < DEPTH_EXT;
  assign wr_in_range = {1'b0, bus.mem_wadrs} < DEPTH_EXT;
  assign rd_idx      = bus.mem_radrs[IDX_W-1:0];
  assign wr_idx      = bus.mem_wadrs[IDX_W-1:0];
  assign wr_hits_rd  = bus.write_mem && wr_in_range && (bus.mem_wadrs == bus.mem_radrs);

  // Single write port shared between the clear sweep and CPU stores.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = clear_cnt_reg;
    ram_wdata = INIT_VALUE;
    if (!resetn) begin
      if (state_reg == CLEAR) begin
        ram_we = 1'b1;
      end else if (bus.write_mem && wr_in_range) begin
        ram_we    = 1'b1;
        ram_waddr = wr_idx;
        ram_wdata = bus.result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_reg       <= CLEAR;
      clear_cnt_reg   <= '0;
      rdata_reg       <= INIT_VALUE;
      rdata_valid_reg <= 1'b0;
      ready_reg       <= 1'b0;
      addr_err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        CLEAR: begin
          rdata_valid_reg <= 1'b0;
          addr_err_reg    <= 1'b0;
          if (clear_cnt_reg == LAST_IDX) begin
            state_reg <= SERVE;
            ready_reg <= 1'b1;
          end else begin
            clear_cnt_reg <= clear_cnt_reg + 1'b1;
          end
        end
        SERVE: begin
          rdata_valid_reg <= bus.read_mem;
          addr_err_reg    <= (bus.read_mem && !rd_in_range) ||
                             (bus.write_mem && !wr_in_range);
          if (bus.read_mem) begin
            // Same-address store in this cycle wins over the stored word.
            if (!rd_in_range)
              rdata_reg <= INIT_VALUE;
            else if (wr_hits_rd)
              rdata_reg <= bus.result;
            else
              rdata_reg <= mem[rd_idx];
          end
        end
        default: state_reg <= CLEAR;
      endcase
    end
  end

  assign bus.instruction_fetch = rdata_reg;
  assign bus.rdata_valid       = rdata_valid_reg;
  assign bus.ready             = ready_reg;
  assign bus.addr_err          = addr_err_reg;
endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder (DEPTH=16): directed scenarios plus random
// traffic, checked every cycle against a word-array model of the memory.
module tb_instr_mem_responder;
  localparam int AW    = 11;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam logic [DW-1:0] INIT = 32'h0000_0000;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  instr_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  instr_mem_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .INIT_VALUE(INIT)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: remaining clear cycles plus a plain word array.
  logic [DW-1:0] model_mem [DEPTH];
  int            clear_left;
  logic [DW-1:0] exp_data;
  logic          exp_valid, exp_ready, exp_err;
  bit            model_live = 0;

  always @(posedge clk) begin
    if (resetn) begin
      clear_left = DEPTH;
      exp_data   = INIT;
      exp_valid  = 0;
      exp_err    = 0;
      exp_ready  = 0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = INIT;
      model_live = 1;
    end else if (model_live && clear_left > 0) begin
      clear_left--;
      exp_valid = 0;
      exp_err   = 0;
      exp_ready = (clear_left == 0);
    end else if (model_live) begin
      int ra, wa;
      ra = int'(bus.mem_radrs);
      wa = int'(bus.mem_wadrs);
      if (bus.write_mem && wa < DEPTH) model_mem[wa] = bus.result;
      if (bus.read_mem) exp_data = (ra < DEPTH) ? model_mem[ra] : INIT;
      exp_valid = bus.read_mem;
      exp_err   = (bus.read_mem && ra >= DEPTH) || (bus.write_mem && wa >= DEPTH);
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      checks += 4;
      if (bus.ready !== exp_ready) begin
        errors++;
        $display("FAIL model_ready t=%0t got=%b exp=%b", $time, bus.ready, exp_ready);
      end
      if (bus.rdata_valid !== exp_valid) begin
        errors++;
        $display("FAIL model_valid t=%0t got=%b exp=%b", $time, bus.rdata_valid, exp_valid);
      end
      if (bus.addr_err !== exp_err) begin
        errors++;
        $display("FAIL model_err t=%0t got=%b exp=%b", $time, bus.addr_err, exp_err);
      end
      if (bus.instruction_fetch !== exp_data) begin
        errors++;
        $display("FAIL model_data t=%0t got=%h exp=%h", $time, bus.instruction_fetch, exp_data);
      end
    end
  end

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Apply one cycle of requests; returns 1 time unit after the edge.
  task automatic step(input logic rd, input logic wr, input int ra, input int wa,
                      input logic [DW-1:0] d);
    bus.read_mem  = rd;
    bus.write_mem = wr;
    bus.mem_radrs = AW'(ra);
    bus.mem_wadrs = AW'(wa);
    bus.result    = d;
    @(posedge clk);
    #1;
    $display("txn t=%0t rd=%b ra=%0d wr=%b wa=%0d d=%h -> if=%h v=%b rdy=%b err=%b",
             $time, rd, ra, wr, wa, d, bus.instruction_fetch, bus.rdata_valid,
             bus.ready, bus.addr_err);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, '0);
  endtask

  // Runs the clear with junk requests; ready must rise on exactly the DEPTH-th edge.
  task automatic run_clear(input string tag);
    for (int i = 1; i <= DEPTH; i++) begin
      step(1, 1, 3, 3, 32'hFFFF_FFFF);
      if (i < DEPTH) check({tag, "_ready_low"}, {31'b0, bus.ready}, 32'd0);
      else           check({tag, "_ready_rise"}, {31'b0, bus.ready}, 32'd1);
      check({tag, "_valid_low"}, {31'b0, bus.rdata_valid}, 32'd0);
    end
  endtask

  initial begin
    resetn = 1;
    bus.read_mem = 0; bus.write_mem = 0;
    bus.mem_radrs = '0; bus.mem_wadrs = '0; bus.result = '0;
    idle();
    idle();
    check("reset_data", bus.instruction_fetch, INIT);
    check("reset_ready", {31'b0, bus.ready}, 32'd0);
    resetn = 0;
    run_clear("clr");

    for (int a = 0; a < DEPTH; a++) begin
      step(1, 0, a, 0, '0);
      check("cleared_word", bus.instruction_fetch, 32'h0);
      check("cleared_valid", {31'b0, bus.rdata_valid}, 32'd1);
    end

    step(0, 1, 0, 5, 32'hE000_0123);
    step(1, 0, 5, 0, '0);
    check("wr_then_rd", bus.instruction_fetch, 32'hE000_0123);

    step(1, 1, 9, 9, 32'h8000_00AA);
    check("collision", bus.instruction_fetch, 32'h8000_00AA);

    step(1, 0, 3, 0, '0);
    check("clear_ignored_wr", bus.instruction_fetch, 32'h0);

    step(1, 0, 20, 0, '0);
    check("oor_rd_data", bus.instruction_fetch, INIT);
    check("oor_rd_err", {31'b0, bus.addr_err}, 32'd1);
    idle();
    check("oor_err_pulse", {31'b0, bus.addr_err}, 32'd0);
    check("idle_valid", {31'b0, bus.rdata_valid}, 32'd0);
    step(0, 1, 0, 20, 32'hDEAD_BEEF);
    check("oor_wr_err", {31'b0, bus.addr_err}, 32'd1);
    for (int a = 0; a < DEPTH; a++) step(1, 0, a, 0, '0);

    step(0, 1, 0, 2, 32'h1234_5678);
    resetn = 1;
    idle();
    check("midreset_valid", {31'b0, bus.rdata_valid}, 32'd0);
    resetn = 0;
    run_clear("reclr");
    step(1, 0, 2, 0, '0);
    check("midreset_cleared", bus.instruction_fetch, 32'h0);

    for (int n = 0; n < 1500; n++) begin
      int ra, wa;
      if ($urandom_range(0, 399) == 0) begin
        resetn = 1;
        idle();
        resetn = 0;
      end
      ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(DEPTH, 2047)) : int'($urandom_range(0, DEPTH - 1));
      wa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(DEPTH, 2047)) : int'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 3) == 0) wa = ra;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, wa, $urandom);
    end

    idle();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
Memory-side responder for the pipelined CPU's fetch/store interface. It accepts read and write requests from the CPU and returns registered read data on instruction_fetch. After reset it runs a self-clear sequence that writes INIT_VALUE (NOOP encoding) to every word before it serves requests. It sits between the CPU and the unified instruction/data storage array.

Parameters:
ADDR_WIDTH, 11, width of mem_radrs/mem_wadrs.
DATA_WIDTH, 32, word width.
DEPTH, 2048, number of implemented words; legal range 2..2^ADDR_WIDTH.
INIT_VALUE, 32'h0000_0000, value written during clear; opcode field 3'b000 = NOOP.

Ports:
clk  input  1  CPU clock; all logic on the rising edge.
resetn  input  1  Synchronous, active-high reset. The port name is kept for codebase consistency; high = reset.
read_mem  input  1  Read request, sampled each cycle.
write_mem  input  1  Write request, sampled each cycle.
mem_radrs  input  ADDR_WIDTH  Read word address.
mem_wadrs  input  ADDR_WIDTH  Write word address.
result  input  DATA_WIDTH  Write data from the CPU.
instruction_fetch  output  DATA_WIDTH  Registered read data.
rdata_valid  output  1  High for one cycle when instruction_fetch carries data for the previous cycle's read.
ready  output  1  High once the clear sequence is complete and requests are being served.
addr_err  output  1  Pulses for one cycle after an out-of-range request (address >= DEPTH).

Behaviour:
- States: CLEAR, SERVE. Reset forces CLEAR on the next edge.
- Reset values: instruction_fetch = INIT_VALUE, rdata_valid = 0, ready = 0, addr_err = 0, clear counter = 0.
- CLEAR state:
  - Each cycle, write INIT_VALUE to array[clear_cnt] and increment clear_cnt.
  - The write at clear_cnt == DEPTH-1 moves the FSM to SERVE.
  - The clear takes exactly DEPTH cycles after reset deasserts. ready rises on the edge that enters SERVE.
  - All read_mem and write_mem requests during CLEAR are ignored. instruction_fetch holds INIT_VALUE, rdata_valid = 0, addr_err = 0.
- SERVE state, read:
  - If read_mem is high in cycle N, instruction_fetch = array[mem_radrs] and rdata_valid = 1 in cycle N+1 (1-cycle latency).
  - If read_mem is low, instruction_fetch holds its last value and rdata_valid = 0.
- SERVE state, write:
  - If write_mem is high, array[mem_wadrs] <= result at the edge.
  - Back-to-back writes are accepted every cycle.
- Simultaneous read and write:
  - Same address: write-first. The read returns the new result value.
  - Different addresses: both complete independently.
- Out of range (address >= DEPTH; only possible when DEPTH < 2^ADDR_WIDTH):
  - A read returns INIT_VALUE with rdata_valid = 1 and addr_err = 1 next cycle.
  - A write is dropped and addr_err = 1 next cycle.
  - addr_err is the OR of both conditions.
- Reset asserted mid-CLEAR or mid-SERVE: the FSM returns to CLEAR, the counter restarts at 0, and the whole array is cleared again. Any in-flight read is discarded (rdata_valid = 0).
- Address wrap: none. Addresses are used as given, and clear_cnt stops at DEPTH-1.
- The CPU must gate its fetches on ready. The block does not queue requests.

Test Plan:
- Reset, then clear (DEPTH=16): hold resetn=1 for 2 cycles, then release -> ready = 0 for 16 cycles and rises on cycle 16. Reading addrs 0..15 then returns 32'h0 with rdata_valid = 1, one cycle after each request.
- Write then read: write 32'hE000_0123 to addr 5, read addr 5 next cycle -> instruction_fetch = 32'hE000_0123 one cycle after the read, rdata_valid = 1.
- Same-address collision: read_mem = write_mem = 1, both addrs 9, result = 32'h8000_00AA -> the next cycle returns 32'h8000_00AA.
- Requests during CLEAR: write_mem = 1 to addr 3 with 32'hFFFF_FFFF during clear; read addr 3 after ready -> returns 32'h0, and rdata_valid stayed 0 throughout clear.
- Out of range (DEPTH=16, ADDR_WIDTH=11): read addr 20 -> INIT_VALUE, rdata_valid = 1, addr_err = 1 for one cycle. Write addr 20 -> addr_err = 1, and no array location changes.
- Mid-operation reset: write 32'h1234_5678 to addr 2, pulse resetn for 1 cycle -> ready = 0 for 16 cycles, then read addr 2 returns 32'h0.
